mygo_chan_fifo: RTL
===================

MYGO_CHAN_FIFO -- requirements
Module: mygo_chan_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, buffer slots (>=1, any integer; power of two not required).
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_data  input  WIDTH  write-side payload.
REQ-007 in_valid  input  1  writer offers in_data.
REQ-008 in_ready  output  1  block accepts a write this cycle.
REQ-009 in_close  input  1  writer closes the channel (Go close()).
REQ-010 out_data  output  WIDTH  head-of-queue payload.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  reader consumes head.
REQ-013 out_closed  output  1  channel closed and drained (Go recv ok=false).
REQ-014 send_err  output  1  sticky: write attempted after close (Go send-on-closed panic).
REQ-015 count  output  CW  current occupancy, 0..DEPTH.

Function
REQ-016 Write fire = in_valid && in_ready; read fire = out_valid && out_ready.
REQ-017 in_ready SHALL be 1 iff count < DEPTH and closed flag is 0; combinational from registered state only (no path from in_valid or out_ready).
REQ-018 out_valid SHALL be 1 iff count > 0; out_data SHALL equal the oldest stored entry (first-word fall-through, no combinational path from in_data).
REQ-019 Write-to-read latency: word written at edge N SHALL appear on out_data with out_valid=1 in cycle after edge N (1 cycle).
REQ-020 Write and read pointers SHALL wrap from DEPTH-1 to 0; ordering SHALL be strict FIFO.
REQ-021 Simultaneous write fire and read fire SHALL leave count unchanged and advance both pointers.
REQ-022 Full (count=DEPTH): in_ready=0 even if out_ready=1 same cycle; no write lost, no overwrite.
REQ-023 Empty (count=0): out_valid=0; an in-cycle write is not bypassed; out_data value is don't-care.
REQ-024 count SHALL increment on write-only, decrement on read-only, hold otherwise.
REQ-025 State machine on channel lifecycle: OPEN -> CLOSING on in_close=1 sampled at edge; CLOSING -> DRAINED when count reaches 0 (or immediately if count=0 at close, including after a same-cycle read of the last entry); DRAINED is terminal until rst.
REQ-026 in_close with a same-cycle write fire: the write SHALL be accepted, then channel closed.
REQ-027 in_close while already CLOSING/DRAINED SHALL have no effect.
REQ-028 In CLOSING, reads SHALL continue normally until empty.
REQ-029 out_closed SHALL be 1 only in DRAINED; out_valid is 0 in DRAINED.
REQ-030 in_valid=1 while not OPEN SHALL set send_err at next edge; send_err remains 1 until rst; data is discarded.

Reset
REQ-031 rst=1 at an edge SHALL clear pointers, count=0, state=OPEN, send_err=0, regardless of in-flight traffic; stored data is discarded.
REQ-032 During and after reset edge: in_ready=1, out_valid=0, out_closed=0, send_err=0, count=0.
REQ-033 Storage array itself SHALL need no reset.

Verification
REQ-034 DEPTH=4, write 5,6,7,8 back-to-back, out_ready=0 -> count=4, in_ready=0 after 4th edge; then out_ready=1 -> reads 5,6,7,8 in order, count returns 0.
REQ-035 DEPTH=3, 10 writes of 1..10 with out_ready=1 continuous -> all 10 read in order, 1-cycle latency, count never exceeds 1, pointers wrap three times.
REQ-036 Full (count=4), in_valid=1 and out_ready=1 same cycle -> read pops head, write refused, count=3 next cycle; next cycle write accepted.
REQ-037 Write 0x2A with in_close=1 same cycle, out_ready=0 -> count=1, in_ready=0, out_closed=0; out_ready=1 -> reads 0x2A, next cycle out_closed=1.
REQ-038 After close, in_valid=1 with 0x99 -> send_err=1, count unchanged; rst pulse -> send_err=0, out_closed=0, in_ready=1.
REQ-039 WIDTH=8, DEPTH=1: rst asserted with count=1 mid-transfer -> count=0, out_valid=0 next cycle; write 0xFF -> read 0xFF.

Source files
------------

// File: rtl/mygo_chan_fifo.sv
// rtl/mygo_chan_fifo.sv - Go-style buffered channel: FWFT FIFO with close/drain lifecycle
module mygo_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_close,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_closed,
    output logic             send_err,
    output logic [CW-1:0]    count
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_OPEN, ST_CLOSING, ST_DRAINED} state_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic             send_err_q, send_err_d;
    logic             wr_fire, rd_fire;

    assign in_ready   = (count_q < CW'(DEPTH)) && (state_q == ST_OPEN);
    assign out_valid  = (count_q != '0);
    assign out_data   = mem_q[rd_ptr_q];
    assign out_closed = (state_q == ST_DRAINED);
    assign send_err   = send_err_q;
    assign count      = count_q;

    assign wr_fire = in_valid && in_ready;
    assign rd_fire = out_valid && out_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        send_err_d = send_err_q | (in_valid && (state_q != ST_OPEN));
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (wr_fire && !rd_fire) begin
            count_d = count_q + CW'(1);
        end else if (rd_fire && !wr_fire) begin
            count_d = count_q - CW'(1);
        end
        // Drain decision looks at post-edge occupancy so a same-cycle last read closes at once
        case (state_q)
            ST_OPEN:    if (in_close) state_d = (count_d == '0) ? ST_DRAINED : ST_CLOSING;
            ST_CLOSING: if (count_d == '0) state_d = ST_DRAINED;
            default:    state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_OPEN;
            send_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            send_err_q <= send_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end
endmodule
